// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day counter.
// A digit pair holds one BCD field (tens and units).
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd_pair_t;

  localparam int SEC_MOD      = 60;
  localparam int MIN_MOD      = 60;
  localparam int HOUR_MOD_DEF = 24;

  // Binary value (0..99) to its BCD digit pair; used for constant terminal values.
  function automatic bcd_pair_t bcd_pair_of(input int value);
    bcd_pair_t pair;
    pair.tens  = bcd_t'(value / 10);
    pair.units = bcd_t'(value % 10);
    return pair;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MOD-1 to 00.
// clr has priority over en; term flags the last value of the range.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output bcd_t tens,
  output bcd_t units,
  output logic term
);

  localparam bcd_pair_t LAST = bcd_pair_of(MOD - 1);

  bcd_pair_t cnt_q;
  bcd_pair_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else if (cnt_q.units == 4'd9) begin
        // Units roll over and tens advance on the same edge.
        cnt_d.units = 4'd0;
        cnt_d.tens  = cnt_q.tens + 4'd1;
      end else begin
        cnt_d.units = cnt_q.units + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tens  = cnt_q.tens;
  assign units = cnt_q.units;
  assign term  = (cnt_q == LAST);

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day counter: 1 Hz prescaler, cascaded sec/min/hour BCD stages,
// set-mode increments (no carry) and a registered end-of-day pulse.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int HOUR_MOD = HOUR_MOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_in,
  input  logic set,
  input  logic mode_sel,
  input  logic increment,
  output bcd_t hr_tens,
  output bcd_t hr_units,
  output bcd_t min_tens,
  output bcd_t min_units,
  output bcd_t sec_tens,
  output bcd_t sec_units,
  output logic tick_out,
  output logic day_rco
);

  localparam int              PW      = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PS_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          increment_q, increment_d;
  logic          day_rco_q, day_rco_d;

  logic run, tick, inc_pulse;
  logic sec_en, sec_rco, sec_term;
  logic min_en, min_rco, min_term;
  logic hr_en, hr_term;

  assign run       = start_in & ~set;
  assign tick      = run & (presc_q == PS_LAST);
  assign inc_pulse = increment & ~increment_q;

  // Set mode parks the prescaler at 0 so the first tick after leaving set
  // comes a full second later; a pause simply holds the count.
  always_comb begin
    presc_d = presc_q;
    if (set) begin
      presc_d = '0;
    end else if (start_in) begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  assign increment_d = increment;

  // Carries only exist in run mode (tick is gated by run), so set-mode
  // increments never ripple into the next field.
  assign sec_en  = tick;
  assign sec_rco = sec_en & sec_term;
  assign min_en  = sec_rco | (set & ~mode_sel & inc_pulse);
  assign min_rco = sec_rco & min_term;
  assign hr_en   = min_rco | (set & mode_sel & inc_pulse);

  assign day_rco_d = min_rco & hr_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      increment_q <= 1'b0;
      day_rco_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      increment_q <= increment_d;
      day_rco_q   <= day_rco_d;
    end
  end

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .en    (sec_en),
    .clr   (set),
    .tens  (sec_tens),
    .units (sec_units),
    .term  (sec_term)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk   (clk),
    .rst   (rst),
    .en    (min_en),
    .clr   (1'b0),
    .tens  (min_tens),
    .units (min_units),
    .term  (min_term)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hr (
    .clk   (clk),
    .rst   (rst),
    .en    (hr_en),
    .clr   (1'b0),
    .tens  (hr_tens),
    .units (hr_units),
    .term  (hr_term)
  );

  assign tick_out = tick;
  assign day_rco  = day_rco_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter (CLK_HZ=4): stimulus queues expected
// states, a negedge monitor pops and compares them against the 24h or 12h instance.
module tb_clock_time_counter;

  logic clk = 1'b0;
  logic rst, start_in, set, mode_sel, increment;

  logic [3:0] a_ht, a_hu, a_mt, a_mu, a_st, a_su;
  logic [3:0] b_ht, b_hu, b_mt, b_mu, b_st, b_su;
  logic       a_tick, a_rco, b_tick, b_rco;

  always #5 clk = ~clk;

  clock_time_counter #(.CLK_HZ(4), .HOUR_MOD(24)) dut24 (
    .clk(clk), .rst(rst), .start_in(start_in), .set(set), .mode_sel(mode_sel),
    .increment(increment),
    .hr_tens(a_ht), .hr_units(a_hu), .min_tens(a_mt), .min_units(a_mu),
    .sec_tens(a_st), .sec_units(a_su), .tick_out(a_tick), .day_rco(a_rco)
  );

  clock_time_counter #(.CLK_HZ(4), .HOUR_MOD(12)) dut12 (
    .clk(clk), .rst(rst), .start_in(start_in), .set(set), .mode_sel(mode_sel),
    .increment(increment),
    .hr_tens(b_ht), .hr_units(b_hu), .min_tens(b_mt), .min_units(b_mu),
    .sec_tens(b_st), .sec_units(b_su), .tick_out(b_tick), .day_rco(b_rco)
  );

  wire [25:0] act24 = {a_ht, a_hu, a_mt, a_mu, a_st, a_su, a_tick, a_rco};
  wire [25:0] act12 = {b_ht, b_hu, b_mt, b_mu, b_st, b_su, b_tick, b_rco};

  typedef struct {
    string      name;
    int         cyc;
    bit         use12;
    logic [25:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [25:0] pack(input int h, input int m, input int s,
                                       input logic t, input logic r);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), t, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input bit u12, input int h, input int m,
                     input int s, input logic t, input logic r);
    exp_t e;
    e.name  = nm;
    e.cyc   = cyc;
    e.use12 = u12;
    e.exp   = pack(h, m, s, t, r);
    sb.push_back(e);
  endtask

  task automatic pulse();
    increment = 1'b1;
    step();
    increment = 1'b0;
    step();
  endtask

  // Monitor: digits/tick/rco are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    logic [25:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        act = e.use12 ? act12 : act24;
        n_cmp++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s (dut%0d, cyc %0d): actual %h required %h",
                   e.name, e.use12 ? 12 : 24, cyc, act, e.exp);
        end else begin
          $display("cyc %0d %s dut%0d ok %h", cyc, e.name, e.use12 ? 12 : 24, act);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_in = 1'b1; set = 1'b0; mode_sel = 1'b0; increment = 1'b0;
    step();
    step();
    chk("reset", 0, 0, 0, 0, 1'b0, 1'b0);
    chk("reset", 1, 0, 0, 0, 1'b0, 1'b0);

    // Free run from reset release: ticks in cycles 3, 7, 11.
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("run_c%0d", i), 0, 0, 0, i / 4, (i % 4) == 3, 1'b0);
      step();
    end
    chk("run_end", 0, 0, 0, 3, 1'b0, 1'b0);

    // Preload 23:59 via set increments, then run seconds up to 58.
    set = 1'b1; mode_sel = 1'b0;
    step();
    chk("set_sec_clr", 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (59) pulse();
    mode_sel = 1'b1;
    repeat (23) pulse();
    chk("preload", 0, 23, 59, 0, 1'b0, 1'b0);
    chk("preload", 1, 11, 59, 0, 1'b0, 1'b0);
    set = 1'b0;
    repeat (232) step();
    chk("at_58", 0, 23, 59, 58, 1'b0, 1'b0);
    repeat (3) step();
    chk("tick_58", 0, 23, 59, 58, 1'b1, 1'b0);
    step();
    chk("at_59", 0, 23, 59, 59, 1'b0, 1'b0);
    repeat (3) step();
    chk("tick_59", 0, 23, 59, 59, 1'b1, 1'b0);
    step();
    chk("day_wrap", 0, 0, 0, 0, 1'b0, 1'b1);
    chk("day_wrap", 1, 0, 0, 0, 1'b0, 1'b1);
    step();
    chk("rco_one_cycle", 0, 0, 0, 0, 1'b0, 1'b0);

    // Minute increments wrap without carrying into hours.
    set = 1'b1; mode_sel = 1'b0;
    step();
    repeat (60) pulse();
    chk("min_60_pulses", 0, 0, 0, 0, 1'b0, 1'b0);
    pulse();
    chk("min_61_pulses", 0, 0, 1, 0, 1'b0, 1'b0);
    chk("min_61_pulses", 1, 0, 1, 0, 1'b0, 1'b0);

    // Hour increments; 12h instance wraps to 00 after 12 pulses.
    mode_sel = 1'b1;
    repeat (11) pulse();
    chk("hr_11", 0, 11, 1, 0, 1'b0, 1'b0);
    chk("hr_11", 1, 11, 1, 0, 1'b0, 1'b0);
    pulse();
    chk("hr_12", 0, 12, 1, 0, 1'b0, 1'b0);
    chk("hr_12_wrap", 1, 0, 1, 0, 1'b0, 1'b0);
    increment = 1'b1;
    step();
    chk("hold_first", 0, 13, 1, 0, 1'b0, 1'b0);
    repeat (9) step();
    chk("hold_10", 0, 13, 1, 0, 1'b0, 1'b0);
    chk("hold_10", 1, 1, 1, 0, 1'b0, 1'b0);
    increment = 1'b0;
    step();

    // Pause at prescaler=2; increments ignored outside set mode.
    set = 1'b0;
    step();
    step();
    chk("pre_pause", 0, 13, 1, 0, 1'b0, 1'b0);
    start_in = 1'b0;
    repeat (10) step();
    pulse();
    repeat (8) step();
    chk("paused", 0, 13, 1, 0, 1'b0, 1'b0);
    chk("paused", 1, 1, 1, 0, 1'b0, 1'b0);
    start_in = 1'b1;
    step();
    chk("resume_tick", 0, 13, 1, 0, 1'b1, 1'b0);
    step();
    chk("resume_sec", 0, 13, 1, 1, 1'b0, 1'b0);
    chk("resume_sec", 1, 1, 1, 1, 1'b0, 1'b0);

    // Reset during set with an increment edge pending.
    set = 1'b1; mode_sel = 1'b1;
    step();
    increment = 1'b1; rst = 1'b1;
    step();
    chk("rst_in_set", 0, 0, 0, 0, 1'b0, 1'b0);
    chk("rst_in_set", 1, 0, 0, 0, 1'b0, 1'b0);

    // Reset mid-second while tick is high.
    rst = 1'b0; increment = 1'b0; set = 1'b0;
    repeat (3) step();
    chk("pre_rst_tick", 0, 0, 0, 0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_mid_sec", 0, 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
